// File: rtl/logmul_seq_ctrl.sv
// Sequencer for an 8x8 Mitchell logarithmic multiplier: a bit-serial
// leading-one scan of both operands, then log add and antilog in one cycle.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   operand handshake (n_var_1 = A, n_var_2 = B)
//   out_valid / out_ready product handshake, c = 16-bit approximate product
//   busy                  high whenever the sequencer is not idle
module logmul_seq_ctrl #(
    parameter int MITCHELL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  n_var_1,
    input  logic [7:0]  n_var_2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] c,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [2:0]  r_cnt;
    logic        r_fnd1;
    logic        r_fnd2;
    logic [2:0]  r_k1;
    logic [2:0]  r_k2;
    logic [15:0] r_c;

    logic        w_accept;
    logic        w_zero;
    logic [6:0]  w_f1;
    logic [6:0]  w_f2;
    logic [7:0]  w_s;
    logic [3:0]  w_kk;
    logic [15:0] w_c;

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_zero   = (n_var_1 == 8'd0) || (n_var_2 == 8'd0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = w_zero ? DONE : SCAN;
                end
            end
            SCAN: begin
                if (r_cnt == 3'd0) begin
                    w_next = CALC;
                end
            end
            CALC: begin
                w_next = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (r_state == IDLE);
        busy      = (r_state != IDLE);
        out_valid = (r_state == DONE);
        c         = r_c;
    end

    // Antilog: the leading one is shifted to bit 7, the 7 bits below it
    // are the fractional part of the log.
    always_comb begin
        w_f1 = 7'(r_a << (3'd7 - r_k1));
        w_f2 = 7'(r_b << (3'd7 - r_k2));
        w_s  = {1'b0, w_f1} + {1'b0, w_f2};
        w_kk = {1'b0, r_k1} + {1'b0, r_k2};
        if (MITCHELL == 0) begin
            w_c = 16'(24'd1 << w_kk);
        end else if (!w_s[7]) begin
            w_c = 16'(((24'd128 + {16'd0, w_s}) << w_kk) >> 7);
        end else begin
            // Fraction sum carried past 1.0: exponent grows by one.
            w_c = 16'(({16'd0, w_s} << w_kk) >> 6);
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= 8'd0;
            r_b    <= 8'd0;
            r_cnt  <= 3'd7;
            r_fnd1 <= 1'b0;
            r_fnd2 <= 1'b0;
            r_k1   <= 3'd0;
            r_k2   <= 3'd0;
            r_c    <= 16'd0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a    <= n_var_1;
                        r_b    <= n_var_2;
                        r_cnt  <= 3'd7;
                        r_fnd1 <= 1'b0;
                        r_fnd2 <= 1'b0;
                        if (w_zero) begin
                            r_c <= 16'd0;
                        end
                    end
                end
                SCAN: begin
                    // Scan from MSB down; only the first one seen is kept.
                    if (!r_fnd1 && r_a[r_cnt]) begin
                        r_k1   <= r_cnt;
                        r_fnd1 <= 1'b1;
                    end
                    if (!r_fnd2 && r_b[r_cnt]) begin
                        r_k2   <= r_cnt;
                        r_fnd2 <= 1'b1;
                    end
                    r_cnt <= r_cnt - 3'd1;
                end
                CALC: begin
                    r_c <= w_c;
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logmul_seq_ctrl.sv
// Randomized self-checking bench for logmul_seq_ctrl with both the
// Mitchell and integer-log builds driven from one stimulus stream.
module tb_logmul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  n_var_1 = 8'd0;
    logic [7:0]  n_var_2 = 8'd0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [15:0] c;
    logic        in_ready0;
    logic        out_valid0;
    logic        busy0;
    logic [15:0] c0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    logmul_seq_ctrl #(.MITCHELL(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .n_var_1(n_var_1), .n_var_2(n_var_2),
        .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .busy(busy)
    );

    logmul_seq_ctrl #(.MITCHELL(0)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready0),
        .n_var_1(n_var_1), .n_var_2(n_var_2),
        .out_valid(out_valid0), .out_ready(out_ready),
        .c(c0), .busy(busy0)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic int ilog2(input int x);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++) begin
            if (x >= (1 << i)) r = i;
        end
        return r;
    endfunction

    // Mitchell: log2(x) ~= k + (x/2^k - 1); antilog 2^(K) * (1 + s).
    function automatic int model(input int a, input int b, input int m);
        int k1, k2, f1, f2, s, kk;
        if (a == 0 || b == 0) return 0;
        k1 = ilog2(a);
        k2 = ilog2(b);
        f1 = ((a * 128) >> k1) - 128;
        f2 = ((b * 128) >> k2) - 128;
        s  = f1 + f2;
        kk = k1 + k2;
        if (m == 0) return 1 << kk;
        if (s < 128) return ((128 + s) << kk) >> 7;
        return (s << kk) >> 6;
    endfunction

    // Runs one transaction from a negedge; returns cycles waited for in_ready.
    task automatic do_txn(input int a, input int b, input int e1,
                          input int e0, input int hold, input bit bp,
                          output int waited);
        int lat;
        int exp_lat;
        logic [15:0] cs, cs0;
        exp_lat = (a == 0 || b == 0) ? 1 : 10;
        n_var_1  = 8'(a);
        n_var_2  = 8'(b);
        in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 1);
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!bp) in_valid = 1'b0;
        end while (!out_valid && lat < 40);
        check($sformatf("lat_%0dx%0d", a, b), 32'(lat), 32'(exp_lat));
        check($sformatf("c_%0dx%0d", a, b), 32'(c), 32'(e1));
        check($sformatf("c0_%0dx%0d", a, b), 32'(c0), 32'(e0));
        cs  = c;
        cs0 = c0;
        for (int i = 0; i < hold; i++) begin
            if (bp) begin
                n_var_1  = 8'($urandom_range(1, 255));
                n_var_2  = 8'($urandom_range(1, 255));
                in_valid = 1'b1;
            end
            @(negedge clk);
            if (bp || i == hold - 1) begin
                check("hold_c", 32'(c), 32'(cs));
                check("hold_c0", 32'(c0), 32'(cs0));
                check("hold_inrdy", 32'(in_ready), 0);
                check("hold_ov", 32'(out_valid), 1);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("ov_clear", 32'(out_valid), 0);
        check("idle_rdy", 32'(in_ready), 1);
    endtask

    initial begin
        int a, b, w, hold;
        bit bp;
        int dir [6][4] = '{
            '{8, 16, 128, 128},
            '{5, 6, 28, 16},
            '{3, 3, 8, 4},
            '{255, 255, 65024, 16384},
            '{1, 1, 1, 1},
            '{0, 77, 0, 0}
        };

        repeat (2) @(negedge clk);
        check("rst_inrdy", 32'(in_ready), 1);
        check("rst_ov", 32'(out_valid), 0);
        check("rst_c", 32'(c), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            do_txn(dir[i][0], dir[i][1], dir[i][2], dir[i][3], 2, 1'b0, w);
        end

        // Backpressure with a persistent source.
        do_txn(200, 99, model(200, 99, 1), model(200, 99, 0), 20, 1'b1, w);
        do_txn(17, 42, model(17, 42, 1), model(17, 42, 0), 1, 1'b0, w);
        check("bp_next_accept", 32'(w), 0);

        // Reset in the middle of the scan.
        n_var_1  = 8'd100;
        n_var_2  = 8'd37;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("scan_busy", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_inrdy", 32'(in_ready), 1);
        check("mrst_ov", 32'(out_valid), 0);
        check("mrst_c", 32'(c), 0);
        check("mrst_busy", 32'(busy), 0);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid || !in_ready) check("mrst_stale", 32'(out_valid), 0);
        end
        out_ready = 1'b0;

        for (int i = 0; i < 60; i++) begin
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            if ($urandom_range(0, 7) == 0) a = 0;
            if ($urandom_range(0, 7) == 0) b = 0;
            if ($urandom_range(0, 3) == 0) a = 1 << $urandom_range(0, 7);
            hold = $urandom_range(1, 4);
            bp   = 1'($urandom_range(0, 1));
            do_txn(a, b, model(a, b, 1), model(a, b, 0), hold, bp, w);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
